// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants one of N requesters by rotating highest-bit priority
// and holds the grant until done, withdrawal, or timeout.

module rr_hi_enc #(
    parameter int W = 2
) (
    input  logic [(1<<W)-1:0] vec,
    output logic [W-1:0]      idx,
    output logic              any
);
    // Later (higher) set bits overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < (1 << W); i++) begin
            if (vec[i]) begin
                idx = W'(i);
                any = 1'b1;
            end
        end
    end
endmodule

module rr_arbiter #(
    parameter int IDX_WIDTH = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [(1<<IDX_WIDTH)-1:0] req,
    input  logic                      done,
    output logic [(1<<IDX_WIDTH)-1:0] gnt,
    output logic [IDX_WIDTH-1:0]      gnt_idx,
    output logic                      gnt_valid,
    output logic                      timeout
);
    localparam int N     = 1 << IDX_WIDTH;
    localparam int CNT_W = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [N-1:0]         gnt_q, gnt_d;
    logic [IDX_WIDTH-1:0] gnt_idx_q, gnt_idx_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;

    logic [N-1:0]         lower_mask;
    logic [N-1:0]         masked;
    logic [IDX_WIDTH-1:0] masked_idx, req_idx, winner;
    logic                 masked_any, req_any;
    logic                 release_now;

    // Only requesters strictly below the last grant are eligible first.
    assign lower_mask = (N'(1) << ptr_q) - N'(1);
    assign masked     = req & lower_mask;

    rr_hi_enc #(.W(IDX_WIDTH)) u_enc_masked (.vec(masked), .idx(masked_idx), .any(masked_any));
    rr_hi_enc #(.W(IDX_WIDTH)) u_enc_req    (.vec(req),    .idx(req_idx),    .any(req_any));

    assign winner = masked_any ? masked_idx : req_idx;

    assign release_now = done || !req[gnt_idx_q] || (TO_EN && (cnt_q == CNT_MAX));

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (req_any) begin
                    state_d   = BUSY;
                    gnt_d     = N'(1) << winner;
                    gnt_idx_d = winner;
                    cnt_d     = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    ptr_d     = gnt_idx_q;
                    // A pulse only when the counter alone forced the release.
                    timeout_d = !done && req[gnt_idx_q];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = (state_q == BUSY);
    assign timeout   = timeout_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (IDX_WIDTH=2, TIMEOUT=4) with hand-computed expectations.

module tb_rr_arbiter;
    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_arbiter #(.IDX_WIDTH(2), .TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 4'b0000; done = 1'b0;
        #23;
        checks++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b idx=%0d valid=%b to=%b required all 0", gnt, gnt_idx, gnt_valid, timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        req = 4'b1011;
        tick();
        checks++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'd3 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_priority: got gnt=%b idx=%0d valid=%b required 1000/3/1", gnt, gnt_idx, gnt_valid);
        end
        $display("reset priority: req=1011 -> gnt=%b", gnt);
        done = 1'b1; req = 4'b0000;
        tick();
        done = 1'b0;
        checks++;
        if (gnt_valid !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL done_release: got valid=%b gnt=%b required 0/0000", gnt_valid, gnt);
        end
    endtask

    task automatic test_rotation();
        logic [1:0] exp_seq [0:8];
        logic [3:0] exp_gnt;
        exp_seq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
        apply_reset();
        req = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            // After grant 1 (k=6) ptr is 1; switch request pattern to 1101.
            if (k == 7) req = 4'b1101;
            tick();
            exp_gnt = 4'b0001 << exp_seq[k];
            checks++;
            if (gnt !== exp_gnt || gnt_idx !== exp_seq[k] || gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL rotation_grant[%0d]: got gnt=%b idx=%0d valid=%b required %b/%0d/1", k, gnt, gnt_idx, gnt_valid, exp_gnt, exp_seq[k]);
            end
            $display("rotation step %0d: req=%b gnt=%b", k, req, gnt);
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            checks++;
            if (gnt_valid !== 1'b0 || gnt !== 4'b0000) begin
                errors++;
                $display("FAIL rotation_idle[%0d]: got valid=%b gnt=%b required 0/0000", k, gnt_valid, gnt);
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_withdrawal();
        apply_reset();
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100) begin
            errors++;
            $display("FAIL withdraw_grant: got gnt=%b required 0100", gnt);
        end
        req = 4'b1011;
        tick();
        checks++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_release: got valid=%b timeout=%b required 0/0", gnt_valid, timeout);
        end
        tick();
        checks++;
        if (gnt !== 4'b0010 || gnt_idx !== 2'd1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_next: got gnt=%b idx=%0d timeout=%b required 0010/1/0", gnt, gnt_idx, timeout);
        end
        $display("withdrawal: drop req[2], next gnt=%b", gnt);
        // Withdrawal coincident with done must behave as done.
        done = 1'b1; req = 4'b0000;
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL done_withdraw: got valid=%b timeout=%b required 0/0", gnt_valid, timeout);
        end
    endtask

    task automatic test_timeout();
        int high_cycles;
        int pulses;
        apply_reset();
        req = 4'b0010;
        tick();
        high_cycles = 0;
        pulses = 0;
        for (int c = 0; c < 20 && gnt_valid; c++) begin
            high_cycles++;
            if (timeout) pulses++;
            tick();
        end
        if (timeout) pulses++;
        checks++;
        if (high_cycles !== 4) begin
            errors++;
            $display("FAIL timeout_length: got %0d busy cycles required 4", high_cycles);
        end
        checks++;
        if (timeout !== 1'b1 || pulses !== 1 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got timeout=%b pulses=%0d valid=%b required 1/1/0", timeout, pulses, gnt_valid);
        end
        tick();
        checks++;
        if (gnt !== 4'b0010 || gnt_valid !== 1'b1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_regrant: got gnt=%b valid=%b timeout=%b required 0010/1/0", gnt, gnt_valid, timeout);
        end
        $display("timeout: busy=%0d cycles, regrant gnt=%b", high_cycles, gnt);
        tick();
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        req = 4'b0000;
        checks++;
        if (gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL done_at_timeout: got valid=%b timeout=%b required 0/0", gnt_valid, timeout);
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            errors++;
            $display("FAIL done_at_timeout_late: got timeout=%b required 0", timeout);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 4'b0100;
        tick();
        checks++;
        if (gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_pre_grant: got valid=%b required 1", gnt_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got gnt=%b idx=%0d valid=%b to=%b required all 0", gnt, gnt_idx, gnt_valid, timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b0001;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
            errors++;
            $display("FAIL async_after: got gnt=%b idx=%0d required 0001/0", gnt, gnt_idx);
        end
        $display("async reset mid-busy, then gnt=%b", gnt);
        done = 1'b1; req = 4'b0000;
        tick();
        done = 1'b0;
    endtask

    task automatic test_stray_done();
        apply_reset();
        req = 4'b0100;
        tick();
        done = 1'b1; req = 4'b0000;
        tick();
        done = 1'b0;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (gnt_valid !== 1'b0 || gnt !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL stray_done: got valid=%b gnt=%b timeout=%b required 0/0000/0", gnt_valid, gnt, timeout);
        end
        req = 4'b1011;
        tick();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL stray_done_ptr: got gnt=%b required 0010", gnt);
        end
        $display("stray done ignored, next gnt=%b", gnt);
        done = 1'b1; req = 4'b0000;
        tick();
        done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_withdrawal();
        test_timeout();
        test_async_reset();
        test_stray_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
